// File: rtl/spike_egress_pkg.sv
// Shared constants and helpers for the spike egress stage.
// Arbitration mode encodings and FIFO pointer sizing.
package spike_egress_pkg;

  localparam logic ARB_RR    = 1'b0;
  localparam logic ARB_FIXED = 1'b1;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ts_fifo.sv
// Per-neuron timestamp FIFO, power-of-two depth.
// Extra pointer bit separates full from empty.
module ts_fifo
  import spike_egress_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr[AW-1:0]];

  // Pointer advance; natural wrap of the extended pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spike_egress_mux.sv
// Spike egress: per-neuron timestamp FIFOs, RR/fixed arbiter,
// valid/ready output register and saturating drop counter.
module spike_egress_mux
  import spike_egress_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int NEURON_ID_W = 4,
  parameter int TS_W        = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int DROP_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   scan_start_en,
  input  logic [NUM_NEURONS-1:0] spike_vec,
  input  logic                   arb_mode,
  output logic                   spike_valid,
  output logic [NEURON_ID_W-1:0] spike_id,
  output logic [TS_W-1:0]        spike_ts,
  input  logic                   spike_ready,
  output logic [DROP_W-1:0]      drop_count,
  output logic                   pending_any
);

  localparam int CW = $clog2(NUM_NEURONS + 1);

  logic [TS_W-1:0]        ts;
  logic [NEURON_ID_W-1:0] rr_ptr;
  logic [NUM_NEURONS-1:0] full;
  logic [NUM_NEURONS-1:0] empty;
  logic [NUM_NEURONS-1:0] pop;
  logic [NUM_NEURONS-1:0] push;
  logic [NUM_NEURONS-1:0] drop;
  logic [TS_W-1:0]        head [NUM_NEURONS];
  logic                   load;
  logic                   grant;
  logic [NEURON_ID_W-1:0] win;
  logic [CW-1:0]          drop_n;
  logic [DROP_W:0]        drop_sum;

  assign load        = !spike_valid || spike_ready;
  assign pending_any = |(~empty);

  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_lane
    assign pop[i]  = load && grant &&
                     (win == NEURON_ID_W'(i));
    assign push[i] = spike_vec[i] && (!full[i] || pop[i]);
    assign drop[i] = spike_vec[i] && full[i] && !pop[i];

    ts_fifo #(
      .W     (TS_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .din   (ts),
      .pop   (pop[i]),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // Winner search; descending scan leaves the first hit in win.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    if (arb_mode == ARB_FIXED) begin
      for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
        if (!empty[i]) begin
          grant = 1'b1;
          win   = NEURON_ID_W'(i);
        end
      end
    end else begin
      for (int k = NUM_NEURONS - 1; k >= 0; k--) begin
        if (!empty[(int'(rr_ptr) + k) % NUM_NEURONS]) begin
          grant = 1'b1;
          win   = NEURON_ID_W'((int'(rr_ptr) + k) % NUM_NEURONS);
        end
      end
    end
  end

  // Population count of lanes dropped this cycle.
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      drop_n = drop_n + CW'(drop[i]);
    end
    drop_sum = {1'b0, drop_count} + (DROP_W + 1)'(drop_n);
  end

  // Window counter and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts         <= '0;
      drop_count <= '0;
    end else begin
      if (scan_start_en) ts <= ts + 1'b1;
      if (drop_sum[DROP_W]) drop_count <= '1;
      else                  drop_count <= drop_sum[DROP_W-1:0];
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_valid <= 1'b0;
      spike_id    <= '0;
      spike_ts    <= '0;
      rr_ptr      <= '0;
    end else if (load) begin
      if (grant) begin
        spike_valid <= 1'b1;
        spike_id    <= win;
        spike_ts    <= head[win];
        if (arb_mode == ARB_RR) begin
          if (int'(win) == NUM_NEURONS - 1) rr_ptr <= '0;
          else                              rr_ptr <= win + 1'b1;
        end
      end else begin
        spike_valid <= 1'b0;
      end
    end
  end

endmodule
